// File: rtl/rotate_right_seq_if.sv
// Request/response bundle for the sequential rotate-right unit.
//   master : drives start/in/rotate, observes out/busy/done (requester side)
//   slave  : the rotate unit itself
interface rotate_right_seq_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
);
  logic              start;
  logic [DATA_W-1:0] in;
  logic [AMT_W-1:0]  rotate;
  logic [DATA_W-1:0] out;
  logic              busy;
  logic              done;

  modport master (output start, in, rotate, input out, busy, done);
  modport slave  (input start, in, rotate, output out, busy, done);
endinterface

// File: rtl/rotate_right_seq.sv
// Multi-cycle rotate-right unit. An operand and amount are captured on a start
// pulse in IDLE; the operand is then rotated right STEP bits per cycle while
// the remaining count is >= STEP, else 1 bit per cycle. The result is
// registered into out on the edge that enters DONE, so out and the one-cycle
// done pulse appear together.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - async active-low reset; discards any operation in flight
//   bus    - slave modport: start/in/rotate request, out/busy/done response
module rotate_right_seq #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rotate_right_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] ONE_A  = AMT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q;
  logic              load_out;

  logic [DATA_W-1:0] rot_step, rot_one;
  assign rot_step = {work_q[STEP-1:0], work_q[DATA_W-1:STEP]};
  assign rot_one  = {work_q[0], work_q[DATA_W-1:1]};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.in;
          cnt_d   = bus.rotate;
          state_d = (bus.rotate == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q >= STEP_A) begin
          work_d = rot_step;
          cnt_d  = cnt_q - STEP_A;
        end else begin
          work_d = rot_one;
          cnt_d  = cnt_q - ONE_A;
        end
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Capture the final work value on the same edge that enters DONE; this
    // covers both the zero-amount path from IDLE and the last RUN step.
    load_out = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      if (load_out) out_q <= work_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_rotate_right_seq.sv
module tb_rotate_right_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  logic [31:0] prev_out = '0;

  always #5 clk = ~clk;

  rotate_right_seq_if #(.DATA_W(32), .AMT_W(5)) bus ();

  rotate_right_seq #(.DATA_W(32), .AMT_W(5), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one request at edge k, then watch 40 cycles: done must appear only
  // after edge k+S, busy must span S+1 samples, out must hold until done.
  // With inject set, a second request is presented through RUN/DONE.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [4:0] amt,
                        input logic [31:0] exp_out, input int s, input bit inject);
    int done_at = -1;
    int ndone = 0;
    int nbusy = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.in     = din;
    bus.rotate = amt;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.in     = 32'hDEAD_BEEF;
    bus.rotate = 5'd9;
    for (int j = 0; j < 40; j++) begin
      if (inject) begin
        bus.start  = (j < 2);
        bus.in     = 32'hFFFF_FFFF;
        bus.rotate = 5'd7;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = j;
          chk({tag, ".out"}, bus.out, exp_out);
        end
      end
      if (bus.busy === 1'b1) nbusy++;
      if (j < s) chk({tag, ".hold"}, bus.out, prev_out);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk({tag, ".lat"}, 32'(done_at), 32'(s));
    chk({tag, ".ndone"}, 32'(ndone), 32'd1);
    chk({tag, ".nbusy"}, 32'(nbusy), 32'(s + 1));
    chk({tag, ".final"}, bus.out, exp_out);
    prev_out = exp_out;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.in     = '0;
    bus.rotate = '0;
    #12;
    chk("rst.out",  bus.out, 32'h0);
    chk("rst.busy", {31'b0, bus.busy}, 32'h0);
    chk("rst.done", {31'b0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zero",  32'hABCD_1234, 5'd0,  32'hABCD_1234, 0,  1'b0);
    run_op("one",   32'h0000_0001, 5'd1,  32'h8000_0000, 1,  1'b0);
    run_op("mixed", 32'h1234_5678, 5'd13, 32'hB3C0_91A2, 4,  1'b0);
    run_op("max",   32'h8000_0001, 5'd31, 32'h0000_0003, 10, 1'b0);
    run_op("busy",  32'h0000_000F, 5'd4,  32'hF000_0000, 1,  1'b1);

    // Reset mid-operation: amount 20 needs 5 RUN cycles; cut it after 2.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.in     = 32'h1234_5678;
    bus.rotate = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid.busy_pre", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid.out",  bus.out, 32'h0);
    chk("mid.busy", {31'b0, bus.busy}, 32'h0);
    chk("mid.done", {31'b0, bus.done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_out = 32'h0;
    run_op("post", 32'h0000_0001, 5'd2, 32'h4000_0000, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rotate_right_seq.md
Name: rotate_right_seq

Overview:
- Multi-cycle 32-bit rotate-right unit for the ALU datapath; the right-direction counterpart of the combinational rotate-left unit.
- Accepts an operand and a 5-bit rotate amount on a start pulse.
- Rotates iteratively, by STEP bits per cycle while the remaining count is at least STEP, otherwise by 1 bit per cycle.
- Returns the result with a one-cycle done pulse. It trades latency for area against a full barrel rotator.

Parameters:
- DATA_W, 32, operand/result width (block verified at 32 only).
- AMT_W, 5, rotate amount width; equals log2(DATA_W).
- STEP, 4, coarse rotate distance per cycle; legal range 2 to DATA_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- in  input  DATA_W  operand; captured on accepted start.
- rotate  input  AMT_W  rotate-right amount; captured on accepted start.
- out  output  DATA_W  registered result; holds last result until the next done.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  single-cycle pulse; out is valid in the same cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low immediately forces state=IDLE and clears work, cnt, out, done and busy to 0.
  - Takes effect mid-operation too; the operation in flight is discarded with no done pulse.
- Internal registers:
  - work, DATA_W bits: operand being rotated.
  - cnt, AMT_W bits: remaining rotate distance.
  - state: IDLE, RUN or DONE.
- IDLE, start=1 at edge k: work<=in, cnt<=rotate.
  - If rotate==0, next state is DONE.
  - Otherwise next state is RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - If cnt>=STEP: work<=work rotated right by STEP, cnt<=cnt-STEP.
  - Otherwise: work<=work rotated right by 1, cnt<=cnt-1.
  - If the new cnt==0, next state is DONE; otherwise stay in RUN.
- Rotate right by n: bit i of the result equals bit (i+n) mod DATA_W of the operand. No bits are lost, no sign or zero fill.
- DONE edge: out<=work is already registered (see below); next state is IDLE.
  - done is high for exactly the one cycle spent in DONE.
- out register: loaded from work on the edge that enters DONE, so out and done appear together.
- Latency:
  - Let S = floor(N/STEP) + (N mod STEP) for amount N; for N==0, S=0.
  - With start accepted at edge k, done is high in the cycle following edge k+S+... specifically after edge k+S for N>0, and after edge k for N==0.
  - busy is high from after edge k through the DONE cycle inclusive.
- start while busy (RUN or DONE): ignored, with no effect on work, cnt or out.
  - The requester must wait for busy=0.
- Back-to-back operations: start asserted in the cycle after done (state IDLE) is accepted.
  - Minimum issue interval is S+2 cycles.
- in and rotate may change freely after the accepting edge; only the captured values are used.
- out is stable outside done cycles. It does not reflect intermediate work values.
- Maximum amount N=31 with STEP=4 gives S=7+3=10 RUN cycles.

Test Plan:
- Zero rotate: in=0xABCD1234, rotate=0, start pulse at edge k -> done=1 after edge k, out=0xABCD1234, busy high for exactly 1 cycle.
- Single bit: in=0x00000001, rotate=1 -> one RUN cycle, done after edge k+1, out=0x80000000.
- Mixed coarse/fine: in=0x12345678, rotate=13 -> S=4, done after edge k+4, out=0xB3C091A2.
- Maximum amount: in=0x80000001, rotate=31 -> S=10, done after edge k+10, out=0x00000003.
  - Cross-check: out equals a rotate left by 1 of the same operand.
- Busy protection: start in=0x0000000F, rotate=4, then pulse start with in=0xFFFFFFFF, rotate=7 during RUN.
  - Second request is ignored; out=0xF0000000; exactly one done pulse.
- Reset mid-op: in=0x12345678, rotate=20, drop rst_n after 2 RUN cycles.
  - out=0, busy=0, done=0 immediately with no clock required.
  - After release, start with in=0x1, rotate=2 -> out=0x40000000.
